imm_gen_stage: RTL
==================

# imm_gen_stage

Registered immediate-generation stage between fetch and decode/execute. It decodes the immediate format of each instruction from its opcode and funct3, then sign- or zero-extends the immediate to XLEN. It also classifies the format and flags opcodes it does not recognise. Each result passes downstream through a valid/ready handshake with a two-entry skid buffer, so a downstream stall never drops or duplicates an instruction.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values 32 or 64.
- TAG_W, 8: width of the opaque sideband tag (e.g. PC index or ROB id) carried with each instruction.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries (branch redirect).
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept; registered, equals "skid entry empty".
- in_instr  in  32  raw instruction word.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output entry holds a result.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  format code (package enum).
- out_illegal  out  1  opcode not recognised for this XLEN.
- out_instr  out  32  instruction passthrough.
- out_tag  out  TAG_W  tag passthrough.

## Operation
Format selection, by opcode (bits 6:0):
- 0000011, 0010011, 1100111, 0001111 → I: instr[31:20], sign-extended.
- 0100011 → S: {instr[31:25], instr[11:7]}, sign-extended.
- 1100011 → B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
- 1101111 → J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
- 0110111, 0010111 → U: {instr[31:12], 12'b0}; bit 31 is sign-extended to XLEN.
- 1110011: funct3[2]=1 → Z, instr[19:15] zero-extended. Otherwise → NONE.
- 0110011 → NONE, imm 0.
- XLEN=64 only: 0011011 → I; 0111011 → NONE. At XLEN=32 both are illegal.
- Any other opcode → NONE, imm 0, out_illegal=1. out_illegal is 0 in every other case.

Buffering:
- Two entries: out (the visible output register) and skid.
- Accept occurs when in_valid && in_ready. Drain occurs when out_valid && out_ready.
- On accept, the computed result loads into out if out is empty or draining this cycle. Otherwise it loads into skid.
- On drain, if skid is full, skid moves to out and skid empties.
- FIFO order is always preserved.
- An accept and a drain in the same cycle with skid empty replaces out; out_valid stays 1.

## Timing
- Latency: accepted instruction to out_valid is 1 cycle, with out empty.
- Sustained throughput is 1 instruction per cycle while out_ready=1.
- in_ready reflects skid occupancy from the previous edge. No combinational path from out_ready to in_ready.
- While out_valid=1 && out_ready=0, all out_* values hold stable.
- Reset values: out_valid=0, in_ready=1, out_imm=0, out_fmt=NONE, out_illegal=0, out_instr=0, out_tag=0. Both entries are emptied. Reset asserted mid-stall discards held entries.
- flush empties both entries on the same edge and sets in_ready=1 next cycle. A simultaneous accept is discarded, since flush has priority. A simultaneous drain still counts downstream.
- rst has priority over flush.

## Structure
- Package imm_gen_pkg holds:
  - 3-bit format enum: I=0, S=1, B=2, J=3, U=4, Z=5, NONE=7.
  - Opcode localparams.
- Sub-module imm_decode: purely combinational (instr → imm, fmt, illegal), parametrised by XLEN. It is reused by the verification model.
- imm_gen_stage instantiates imm_decode and owns the two-entry skid logic.

## Test plan
- XLEN=32, in_instr=0xFFF00093 (addi x1,x0,-1) → next cycle out_imm=0xFFFFFFFF, out_fmt=I, out_illegal=0.
- in_instr=0xFE112E23 (sw x1,-4(x2)) → out_imm=0xFFFFFFFC, fmt=S. Then 0x3401D073 (csrrwi) → out_imm=0x00000003, fmt=Z.
- XLEN=64, in_instr=0x800000B7 (lui) → out_imm=0xFFFFFFFF80000000, fmt=U. Opcode 0011011 is legal at XLEN=64 and gives out_illegal=1 at XLEN=32.
- Backpressure:
  - Stimulus: stream tags 1,2,3 with out_ready=0 for 3 cycles.
  - Required: tag 1 held on out; tag 2 in skid; in_ready=0; tag 3 waits upstream.
  - Then release out_ready: outputs 1,2,3 in order, no duplication.
- flush asserted while both entries are full and in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed and incoming entries never appear on the output.
- Reset asserted mid-stall → all outputs at their reset values next cycle. Random-opcode sweep against the imm_decode reference model shows zero mismatches.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - immediate format codes and base/RV64 opcode constants
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_J    = 3'd3,
        FMT_U    = 3'd4,
        FMT_Z    = 3'd5,
        FMT_NONE = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_IMM     = 7'b0010011;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_FENCE   = 7'b0001111;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OP_REG     = 7'b0110011;
    localparam logic [6:0] OP_IMM_32  = 7'b0011011;
    localparam logic [6:0] OP_REG_32  = 7'b0111011;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational opcode to immediate format, extended value and legality
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o,
    output logic            illegal_o
);

    localparam bit IS_RV64 = (XLEN == 64);

    logic [6:0] opcode;
    logic       sgn;

    assign opcode = instr_i[6:0];
    assign sgn    = instr_i[31];

    always_comb begin
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_FENCE: fmt_o = FMT_I;
            OP_STORE:                           fmt_o = FMT_S;
            OP_BRANCH:                          fmt_o = FMT_B;
            OP_JAL:                             fmt_o = FMT_J;
            OP_LUI, OP_AUIPC:                   fmt_o = FMT_U;
            OP_SYSTEM:                          fmt_o = instr_i[14] ? FMT_Z : FMT_NONE;
            OP_REG:                             fmt_o = FMT_NONE;
            OP_IMM_32: begin
                if (IS_RV64) fmt_o = FMT_I;
                else         illegal_o = 1'b1;
            end
            OP_REG_32:                          illegal_o = !IS_RV64;
            default:                            illegal_o = 1'b1;
        endcase
    end

    // instr[31] is folded into the replicated sign field, so every field below
    // starts one bit lower than its architectural top bit.
    always_comb begin
        imm_o = '0;
        case (fmt_o)
            FMT_I:   imm_o = {{(XLEN-11){sgn}}, instr_i[30:20]};
            FMT_S:   imm_o = {{(XLEN-11){sgn}}, instr_i[30:25], instr_i[11:7]};
            FMT_B:   imm_o = {{(XLEN-12){sgn}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_J:   imm_o = {{(XLEN-20){sgn}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            FMT_U:   imm_o = {{(XLEN-31){sgn}}, instr_i[30:12], 12'b0};
            FMT_Z:   imm_o = {{(XLEN-5){1'b0}}, instr_i[19:15]};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered immediate generation with a two-entry skid buffer
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output imm_fmt_e         out_fmt,
    output logic             out_illegal,
    output logic [31:0]      out_instr,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i   (in_instr),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    logic             out_valid_q,   out_valid_d;
    logic [XLEN-1:0]  out_imm_q,     out_imm_d;
    imm_fmt_e         out_fmt_q,     out_fmt_d;
    logic             out_illegal_q, out_illegal_d;
    logic [31:0]      out_instr_q,   out_instr_d;
    logic [TAG_W-1:0] out_tag_q,     out_tag_d;

    logic             skid_valid_q,   skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q,     skid_imm_d;
    imm_fmt_e         skid_fmt_q,     skid_fmt_d;
    logic             skid_illegal_q, skid_illegal_d;
    logic [31:0]      skid_instr_q,   skid_instr_d;
    logic [TAG_W-1:0] skid_tag_q,     skid_tag_d;

    logic accept;
    logic drain;

    // in_ready depends only on skid state, keeping out_ready off the upstream path.
    assign accept = in_valid && !skid_valid_q;
    assign drain  = out_valid_q && out_ready;

    always_comb begin
        out_valid_d    = out_valid_q;
        out_imm_d      = out_imm_q;
        out_fmt_d      = out_fmt_q;
        out_illegal_d  = out_illegal_q;
        out_instr_d    = out_instr_q;
        out_tag_d      = out_tag_q;
        skid_valid_d   = skid_valid_q;
        skid_imm_d     = skid_imm_q;
        skid_fmt_d     = skid_fmt_q;
        skid_illegal_d = skid_illegal_q;
        skid_instr_d   = skid_instr_q;
        skid_tag_d     = skid_tag_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain && skid_valid_q) begin
            out_imm_d     = skid_imm_q;
            out_fmt_d     = skid_fmt_q;
            out_illegal_d = skid_illegal_q;
            out_instr_d   = skid_instr_q;
            out_tag_d     = skid_tag_q;
            skid_valid_d  = 1'b0;
        end else if (accept && (!out_valid_q || drain)) begin
            out_valid_d   = 1'b1;
            out_imm_d     = dec_imm;
            out_fmt_d     = dec_fmt;
            out_illegal_d = dec_illegal;
            out_instr_d   = in_instr;
            out_tag_d     = in_tag;
        end else if (accept) begin
            skid_valid_d   = 1'b1;
            skid_imm_d     = dec_imm;
            skid_fmt_d     = dec_fmt;
            skid_illegal_d = dec_illegal;
            skid_instr_d   = in_instr;
            skid_tag_d     = in_tag;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_imm_q      <= '0;
            out_fmt_q      <= FMT_NONE;
            out_illegal_q  <= 1'b0;
            out_instr_q    <= '0;
            out_tag_q      <= '0;
            skid_valid_q   <= 1'b0;
            skid_imm_q     <= '0;
            skid_fmt_q     <= FMT_NONE;
            skid_illegal_q <= 1'b0;
            skid_instr_q   <= '0;
            skid_tag_q     <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_imm_q      <= out_imm_d;
            out_fmt_q      <= out_fmt_d;
            out_illegal_q  <= out_illegal_d;
            out_instr_q    <= out_instr_d;
            out_tag_q      <= out_tag_d;
            skid_valid_q   <= skid_valid_d;
            skid_imm_q     <= skid_imm_d;
            skid_fmt_q     <= skid_fmt_d;
            skid_illegal_q <= skid_illegal_d;
            skid_instr_q   <= skid_instr_d;
            skid_tag_q     <= skid_tag_d;
        end
    end

    assign in_ready    = !skid_valid_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_fmt     = out_fmt_q;
    assign out_illegal = out_illegal_q;
    assign out_instr   = out_instr_q;
    assign out_tag     = out_tag_q;

endmodule
